// File: rtl/bcd_to_binary_decoder_pkg.sv
// Shared definitions for the BCD-to-binary decoder: default sizing, FSM
// encoding and the reverse double-dabble adjust constants.
package bcd_to_binary_decoder_pkg;

    localparam int DEFAULT_DIGITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESHOLD  = 4'd8;
    localparam logic [3:0] ADJ_CORRECTION = 4'd3;

    // Smallest width w such that 10^digits - 1 fits, i.e. 2^w >= 10^digits.
    function automatic int min_bin_w(input int digits);
        longint limit;
        int     w;
        limit = 64'd1;
        for (int i = 0; i < digits; i++) begin
            limit = limit * 64'd10;
        end
        w = 0;
        while ((64'd1 << w) < limit) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_binary_decoder_nibble_adjust.sv
// One BCD nibble correction step of reverse double-dabble: a nibble that
// received a shifted-in tens bit (value >= 8) is reduced by 3.
module bcd_nibble_adjust
    import bcd_to_binary_decoder_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    // Nibble-local subtract; no borrow crosses into neighbouring digits.
    always_comb begin
        adjusted = nibble;
        if (nibble >= ADJ_THRESHOLD) begin
            adjusted = nibble - ADJ_CORRECTION;
        end else begin
            adjusted = nibble;
        end
    end

endmodule

// File: rtl/bcd_to_binary_decoder.sv
// Sequential packed-BCD to binary converter behind a start/done handshake.
// Illegal digits (> 9) complete immediately with err set and a zero result.
module bcd_to_binary_decoder
    import bcd_to_binary_decoder_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int BIN_W  = min_bin_w(DIGITS)
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int WORK_W = 4*DIGITS + BIN_W;
    localparam int STEP_W = $clog2(BIN_W + 1);

    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_bin_w
        $error("BIN_W too small to hold the largest DIGITS-digit BCD value");
    end

    state_t              state_r;
    logic [WORK_W-1:0]   work_r;
    logic [WORK_W-1:0]   shifted_s;
    logic [WORK_W-1:0]   work_next_s;
    logic [STEP_W-1:0]   step_r;
    logic [DIGITS-1:0]   digit_bad_s;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [BIN_W-1:0]    bin_out_r;

    assign shifted_s                = work_r >> 1;
    assign work_next_s[BIN_W-1:0]   = shifted_s[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_nibble_adjust u_adjust (
            .nibble   (shifted_s[BIN_W + 4*g +: 4]),
            .adjusted (work_next_s[BIN_W + 4*g +: 4])
        );
        assign digit_bad_s[g] = (bcd_in[4*g +: 4] > 4'd9);
    end

    // Handshake FSM, conversion datapath and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            work_r    <= '0;
            step_r    <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            bin_out_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ready_r <= 1'b0;
                        if (|digit_bad_s) begin
                            state_r   <= ST_DONE;
                            done_r    <= 1'b1;
                            err_r     <= 1'b1;
                            bin_out_r <= '0;
                        end else begin
                            state_r <= ST_CONV;
                            work_r  <= {bcd_in, {BIN_W{1'b0}}};
                            step_r  <= '0;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    work_r <= work_next_s;
                    step_r <= step_r + STEP_W'(1);
                    // The final step's shifted low bits are the binary result.
                    if (step_r == STEP_W'(BIN_W - 1)) begin
                        state_r   <= ST_DONE;
                        bin_out_r <= work_next_s[BIN_W-1:0];
                        err_r     <= 1'b0;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign bin_out = bin_out_r;

endmodule

// File: tb/tb_bcd_to_binary_decoder.sv
// Directed, table-driven bench for bcd_to_binary_decoder (DIGITS=2, BIN_W=7).
module tb_bcd_to_binary_decoder;

    logic       clk_in;
    logic       reset;
    logic       start;
    logic [7:0] bcd_in;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] bin_out;

    int checks;
    int errors;

    bcd_to_binary_decoder #(.DIGITS(2), .BIN_W(7)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] bin;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Issues one start, waits (bounded) for done, checks latency/result/pulse width.
    task automatic convert(input string name, input logic [7:0] bcd,
                           input logic [6:0] exp_bin, input logic exp_err,
                           input int exp_lat);
        int cycles;
        int conv_ok;
        check({name, "_ready"}, int'(ready), 1);
        bcd_in = bcd;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        cycles  = 0;
        conv_ok = 1;
        while (done !== 1'b1 && cycles < 20) begin
            if (!(busy === 1'b1 && ready === 1'b0)) conv_ok = 0;
            tick;
            cycles++;
        end
        check({name, "_done"}, int'(done), 1);
        check({name, "_lat"}, cycles, exp_lat);
        check({name, "_bin"}, int'(bin_out), int'(exp_bin));
        check({name, "_err"}, int'(err), int'(exp_err));
        check({name, "_busyconv"}, conv_ok, 1);
        tick;
        check({name, "_pulse"}, int'(done), 0);
        check({name, "_hold"}, int'(bin_out), int'(exp_bin));
    endtask

    initial begin
        int seen_done;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 8'h00;

        vecs[0] = '{8'h99, 7'd99, 1'b0, 7};
        vecs[1] = '{8'h00, 7'd0,  1'b0, 7};
        vecs[2] = '{8'h42, 7'd42, 1'b0, 7};
        vecs[3] = '{8'h10, 7'd10, 1'b0, 7};
        vecs[4] = '{8'h1A, 7'd0,  1'b1, 0};
        vecs[5] = '{8'hF3, 7'd0,  1'b1, 0};
        vecs[6] = '{8'h25, 7'd25, 1'b0, 7};

        tick;
        tick;
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_bin", int'(bin_out), 0);
        reset = 1'b0;
        tick;

        // Table vectors, back-to-back on the first ready cycle.
        for (int i = 0; i < 7; i++) begin
            convert($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin,
                    vecs[i].err, vecs[i].lat);
        end

        // Every legal two-digit code.
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                convert($sformatf("sweep_%0d%0d", t, u), {4'(t), 4'(u)},
                        7'(10*t + u), 1'b0, 7);
            end
        end

        // Start and bcd_in disturbed mid-conversion must be ignored.
        check("ign_ready", int'(ready), 1);
        bcd_in = 8'h37;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        tick;
        tick;
        tick;
        start  = 1'b1;
        bcd_in = 8'h88;
        tick;
        start  = 1'b0;
        bcd_in = 8'h55;
        seen_done = 0;
        for (int c = 0; c < 3; c++) begin
            check("ign_busy", int'(busy), 1);
            tick;
        end
        check("ign_done", int'(done), 1);
        check("ign_bin", int'(bin_out), 37);
        check("ign_err", int'(err), 0);
        for (int c = 0; c < 10; c++) begin
            tick;
            if (done === 1'b1) seen_done++;
        end
        check("ign_single_done", seen_done, 0);

        // Asynchronous reset at step 4 abandons the conversion.
        bcd_in = 8'h64;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        tick;
        tick;
        tick;
        tick;
        check("arst_busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("arst_ready", int'(ready), 1);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_err", int'(err), 0);
        check("arst_bin", int'(bin_out), 0);
        seen_done = 0;
        tick;
        tick;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (done === 1'b1) seen_done++;
        end
        check("arst_no_done", seen_done, 0);
        convert("arst_retry", 8'h64, 7'd64, 1'b0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_decoder.md
Name: bcd_to_binary_decoder

Overview:
- Sequential decoder that converts a packed multi-digit BCD value, as produced by the team's BCD counters, back to plain binary.
- Uses the reverse double-dabble algorithm: shift right, then subtract 3 from every BCD nibble ≥ 8.
- Sits between BCD-coded counter outputs and any arithmetic or compare logic that needs binary, behind a start/done handshake.
- Also flags illegal BCD digits (values above 9).

Parameters:
- DIGITS, 2, number of BCD digits on bcd_in.
- BIN_W, 7, binary output width; must satisfy 10^DIGITS − 1 < 2^BIN_W. Equals the number of conversion steps.

Ports:
- clk_in  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 (units) in [3:0], tens in [7:4], and so on.
- ready  output  1  high in IDLE only.
- busy  output  1  high during CONV.
- done  output  1  one-cycle pulse when result is valid.
- err  output  1  valid with done; 1 if any input digit > 9.
- bin_out  output  BIN_W  result; held stable from done until the next done.

Behaviour:
- Reset (asynchronous, any time, including mid-conversion): state=IDLE, ready=1, busy=0, done=0, err=0, bin_out=0, internal shift register=0. Any conversion in progress is abandoned and no done is produced.
- States: IDLE, CONV, DONE.
- IDLE, start=1 at edge k, all digits ≤ 9:
  - latch work register W = {bcd_in, BIN_W'b0}; step counter = 0; go to CONV.
  - busy=1 and ready=0 from edge k onward.
- IDLE, start=1 at edge k, any digit > 9:
  - latch nothing; go straight to DONE with err=1 and bin_out=0.
  - done is high in the cycle after edge k.
- CONV, each edge:
  - logically shift W right by 1 (MSB filled with 0);
  - then, for each BCD nibble of the shifted value, if nibble ≥ 8, subtract 3 from it (nibble-local, no borrow between nibbles);
  - increment the step counter.
  - After BIN_W steps (edge k+BIN_W), latch bin_out = W[BIN_W-1:0] (the shifted result), set err=0, and go to DONE.
- DONE: done=1 for exactly one cycle (cycle after edge k+BIN_W); next edge returns to IDLE, done=0.
- Latency: start sampled at edge k gives done high in the cycle following edge k+BIN_W. For defaults that is 7 clocks; the next start can be accepted at edge k+BIN_W+1.
- start while busy or in DONE is ignored. bcd_in changes after the accepted start have no effect.
- err and bin_out hold their values until the next done. On an error completion, bin_out is forced to 0.
- Boundary cases:
  - bcd_in=0 yields 0.
  - Max legal value (99 for DIGITS=2) yields 7'd99; no overflow is possible given the BIN_W constraint.
  - The step counter wraps only through reset or re-entry from IDLE.

Decomposition:
- Shared package holds:
  - default DIGITS;
  - a function computing the minimum BIN_W from DIGITS;
  - the state encoding constants (IDLE=2'd0, CONV=2'd1, DONE=2'd2);
  - the BCD adjust constants (threshold 8, correction 3).
- One natural combinational sub-module: bcd_nibble_adjust. It takes a 4-bit nibble and returns the nibble minus 3 if it is ≥ 8, otherwise passes it through. It is instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then start with bcd_in=8'h99 → done 7 cycles after start, bin_out=7'd99, err=0; ready=0 and busy=1 throughout conversion.
- bcd_in=8'h00, then 8'h42, then 8'h10 (back-to-back, each start issued on the first ready cycle) → bin_out 0, 42, 10; done exactly one cycle each.
- Exhaustive sweep of 8'h00–8'h99 over legal BCD codes → bin_out equals 10*tens + units for all 100 cases.
- bcd_in=8'h1A (and separately 8'hF3) → done one cycle after start, err=1, bin_out=0; a following legal 8'h25 gives err=0, bin_out=25.
- Start on 8'h37; pulse start with 8'h88 at conversion step 3; change bcd_in mid-conversion → second start ignored, result 37, single done pulse.
- Start on 8'h64; assert reset at step 4 → all outputs 0 and ready=1 immediately (asynchronous), no done pulse; after release, 8'h64 converts to 64.
